apb_req_arbiter: RTL and testbench

- Shares the single APB master's CPU-side command port between two requesters (req0 = CPU core, req1 = debug/DMA port).
- Performs round-robin arbitration and latches the granted command.
- Drives the master's enable/select/addr/data for the required number of cycles, then waits for the master's ready to rise.
- Returns a one-cycle done or timeout-error pulse to the granted requester.

---
 rtl/apb_req_arbiter.sv | 172 +++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port between two requesters.
// Latches the winning command, drives enable for a fixed window, then waits for ready.
module apb_req_arbiter #(
    parameter int SEL_W          = 8,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 21,
    parameter int ENABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              req0_done,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              req1_done,
    output logic              req1_err,
    output logic              m_enable,
    output logic [SEL_W-1:0]  m_sel,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              grant
);

    localparam int CNT_MAX = (ENABLE_CYCLES > TIMEOUT_CYCLES) ? ENABLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] EN_LAST = CNT_W'(ENABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, GAP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                m_enable_q, m_enable_d;
    logic [SEL_W-1:0]    m_sel_q, m_sel_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [1:0]          ready_q, ready_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic                m_ready_q;
    logic                rise;
    logic                win;

    // Only a fresh rising edge of ready completes a transfer; a level left over
    // from the previous transfer must not.
    assign rise = m_ready & ~m_ready_q;
    assign win  = req1_valid & (~req0_valid | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        m_enable_d   = m_enable_q;
        m_sel_d      = m_sel_q;
        m_addr_d     = m_addr_q;
        m_data_d     = m_data_q;
        ready_d      = 2'b00;
        done_d       = 2'b00;
        err_d        = 2'b00;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    m_sel_d      = win ? req1_sel  : req0_sel;
                    m_addr_d     = win ? req1_addr : req0_addr;
                    m_data_d     = win ? req1_data : req0_data;
                    ready_d      = win ? 2'b10 : 2'b01;
                    grant_d      = win;
                    last_grant_d = win;
                    m_enable_d   = 1'b1;
                    cnt_d        = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == EN_LAST) begin
                    m_enable_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (rise) begin
                    done_d  = grant_q ? 2'b10 : 2'b01;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = grant_q ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                // Hold enable low until the master drops ready, bounded by the timeout.
                if (!m_ready || cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            m_enable_q   <= 1'b0;
            m_sel_q      <= '0;
            m_addr_q     <= '0;
            m_data_q     <= '0;
            ready_q      <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            m_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            m_enable_q   <= m_enable_d;
            m_sel_q      <= m_sel_d;
            m_addr_q     <= m_addr_d;
            m_data_q     <= m_data_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            m_ready_q    <= m_ready;
        end
    end

    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];
    assign m_enable   = m_enable_q;
    assign m_sel      = m_sel_q;
    assign m_addr     = m_addr_q;
    assign m_data     = m_data_q;
    assign busy       = (state_q != IDLE);
    assign grant      = grant_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: single transfer, stray pulse, timeout,
// stale ready, async reset mid-transfer and round-robin alternation.
module tb_apb_req_arbiter;

    localparam int SEL_W  = 8;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 21;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req0_valid, req1_valid;
    logic [SEL_W-1:0]  req0_sel, req1_sel;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req0_done, req0_err;
    logic              req1_ready, req1_done, req1_err;
    logic              m_enable;
    logic [SEL_W-1:0]  m_sel;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              busy;
    logic              grant;

    logic [1:0] rdy, done_v, err_v;
    assign rdy    = {req1_ready, req0_ready};
    assign done_v = {req1_done, req0_done};
    assign err_v  = {req1_err, req0_err};

    int vectors     = 0;
    int miscompares = 0;

    apb_req_arbiter #(
        .SEL_W(SEL_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ENABLE_CYCLES(2), .TIMEOUT_CYCLES(32)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
        .m_enable(m_enable), .m_sel(m_sel), .m_addr(m_addr), .m_data(m_data),
        .m_ready(m_ready), .busy(busy), .grant(grant)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer with both requesters held valid.
    task automatic do_xfer(input logic g, input logic [7:0] a);
        step();
        check("rr_grant", 32'(grant), 32'(g));
        check("rr_ready", 32'(rdy), g ? 32'd2 : 32'd1);
        check("rr_addr",  32'(m_addr), 32'(a));
        check("rr_en_hi1", 32'(m_enable), 32'd1);
        step();
        check("rr_en_hi2", 32'(m_enable), 32'd1);
        check("rr_ready_clr", 32'(rdy), 32'd0);
        step();
        check("rr_en_wait", 32'(m_enable), 32'd0);
        m_ready = 1'b1;
        step();
        check("rr_done", 32'(done_v), g ? 32'd2 : 32'd1);
        check("rr_err", 32'(err_v), 32'd0);
        step();
        check("rr_gap_en", 32'(m_enable), 32'd0);
        check("rr_done_clr", 32'(done_v), 32'd0);
        m_ready = 1'b0;
        step();
        check("rr_idle", 32'({busy, m_enable}), 32'd0);
    endtask

    initial begin
        PRESET = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_sel = '0; req0_addr = '0; req0_data = '0;
        req1_sel = '0; req1_addr = '0; req1_data = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check("reset_ctrl", 32'({m_enable, busy, grant, rdy, done_v, err_v}), 32'd0);
        check("reset_addr", 32'(m_addr), 32'd0);
        check("reset_data", 32'(m_data), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Single req0 transfer, ready rises a few cycles into WAIT.
        req0_valid = 1'b1; req0_sel = 8'h01; req0_addr = 8'h10; req0_data = 21'h1ABCD;
        step();
        check("t1_ready", 32'(rdy), 32'd1);
        check("t1_en", 32'(m_enable), 32'd1);
        check("t1_addr", 32'(m_addr), 32'h10);
        check("t1_sel", 32'(m_sel), 32'h01);
        check("t1_data", 32'(m_data), 32'h1ABCD);
        check("t1_grant", 32'(grant), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        req0_valid = 1'b0;
        step();
        check("t1_en2", 32'(m_enable), 32'd1);
        check("t1_ready_clr", 32'(rdy), 32'd0);
        step();
        check("t1_en_fall", 32'(m_enable), 32'd0);
        step();
        step();
        step();
        check("t1_no_done", 32'(done_v), 32'd0);
        m_ready = 1'b1;
        step();
        check("t1_done", 32'(done_v), 32'd1);
        step();
        check("t1_done_clr", 32'(done_v), 32'd0);
        check("t1_gap_busy", 32'(busy), 32'd1);
        m_ready = 1'b0;
        step();
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_addr_hold", 32'(m_addr), 32'h10);

        // req1 pulsed for one cycle while req0 is being served.
        req0_valid = 1'b1;
        req1_sel = 8'h02; req1_addr = 8'h77; req1_data = 21'h00777;
        step();
        check("t2_ready0", 32'(rdy), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        step();
        check("t2_r1_a", 32'({req1_ready, req1_done, req1_err}), 32'd0);
        req1_valid = 1'b0;
        step();
        check("t2_r1_b", 32'({req1_ready, req1_done, req1_err}), 32'd0);
        m_ready = 1'b1;
        step();
        check("t2_done0", 32'(done_v), 32'd1);
        step();
        m_ready = 1'b0;
        step();
        step();
        check("t2_idle", 32'(busy), 32'd0);
        check("t2_r1_c", 32'({req1_ready, req1_done, req1_err}), 32'd0);
        check("t2_addr", 32'(m_addr), 32'h10);

        // req1 with ready never rising: error after TIMEOUT_CYCLES in WAIT.
        req1_valid = 1'b1;
        step();
        check("t3_ready1", 32'(rdy), 32'd2);
        check("t3_grant", 32'(grant), 32'd1);
        check("t3_addr", 32'(m_addr), 32'h77);
        req1_valid = 1'b0;
        step();
        step();
        check("t3_wait", 32'({busy, m_enable}), 32'b10);
        for (int i = 0; i < 31; i++) begin
            step();
            check("t3_quiet", 32'({done_v, err_v}), 32'd0);
        end
        step();
        check("t3_err", 32'(err_v), 32'd2);
        check("t3_no_done", 32'(done_v), 32'd0);
        step();
        check("t3_idle", 32'({busy, err_v}), 32'd0);

        // Next request issued with ready already high: stale level is ignored.
        m_ready = 1'b1;
        req0_valid = 1'b1; req0_addr = 8'h44;
        step();
        check("t4_ready0", 32'(rdy), 32'd1);
        check("t4_addr", 32'(m_addr), 32'h44);
        req0_valid = 1'b0;
        step();
        step();
        check("t4_wait", 32'(m_enable), 32'd0);
        step();
        check("t4_stale", 32'(done_v), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        m_ready = 1'b0;
        step();
        check("t4_low", 32'(done_v), 32'd0);
        m_ready = 1'b1;
        step();
        check("t4_done", 32'(done_v), 32'd1);
        step();
        m_ready = 1'b0;
        step();
        check("t4_idle", 32'(busy), 32'd0);

        // Async reset in the middle of WAIT.
        req1_valid = 1'b1; req1_addr = 8'h55;
        step();
        check("t5_grant1", 32'(grant), 32'd1);
        req1_valid = 1'b0;
        step();
        step();
        step();
        #3;
        PRESET = 1'b1;
        #1;
        check("t5_rst_ctrl", 32'({m_enable, busy, grant, rdy, done_v, err_v}), 32'd0);
        check("t5_rst_addr", 32'(m_addr), 32'd0);
        check("t5_rst_data", 32'(m_data), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Both continuously valid: req0 first, then strict alternation.
        req0_addr = 8'h20; req1_addr = 8'h30;
        req0_valid = 1'b1; req1_valid = 1'b1;
        do_xfer(1'b0, 8'h20);
        do_xfer(1'b1, 8'h30);
        do_xfer(1'b0, 8'h20);
        do_xfer(1'b1, 8'h30);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
